// File: rtl/soh_arbiter.sv
// soh_arbiter: two-requester arbiter in front of a shared combinational operand handler
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqK_valid/ready (K = 0,1)     request handshake; ready is combinational
//   reqK_rb/imm/sel                request operands (32/21/3 bits)
//   soh_rb/soh_i/soh_s             operands latched at accept, driven to the handler
//   soh_n                          handler result, sampled while in EXEC
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_data                response owner and registered result
//   busy                           high outside IDLE
//   timeout_err                    pulses in the RESP cycle whose stall drops the response
//
// Parameter HOLD_TIMEOUT: rsp_ready-low RESP cycles tolerated before the response is dropped.
// Macro SOH_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module soh_arbiter #(
    parameter int HOLD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rb,
    input  logic [20:0] req0_imm,
    input  logic [2:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rb,
    input  logic [20:0] req1_imm,
    input  logic [2:0]  req1_sel,
    output logic [31:0] soh_rb,
    output logic [20:0] soh_i,
    output logic [2:0]  soh_s,
    input  logic [31:0] soh_n,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] soh_rb_q, soh_rb_d, rsp_data_q, rsp_data_d;
    logic [20:0] soh_i_q, soh_i_d;
    logic [2:0]  soh_s_q, soh_s_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rsp_id_q, rsp_id_d, last_q, last_d;
    logic        gnt, accept, timeout;
`ifdef SOH_ARB_FIXED_PRIO_EN
    assign gnt = !req0_valid;
`else
    // On a tie the requester not granted last wins; otherwise whoever is valid.
    assign gnt = (req0_valid && req1_valid) ? !last_q : req1_valid;
`endif
    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state_q == IDLE) && req0_valid && !gnt;
    assign req1_ready = (state_q == IDLE) && req1_valid && gnt;
    // This stalled cycle is the HOLD_TIMEOUT-th one; rsp_ready high always wins.
    assign timeout    = (state_q == RESP) && !rsp_ready && (cnt_q == 8'(HOLD_TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            soh_rb_q   <= '0;
            soh_i_q    <= '0;
            soh_s_q    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            soh_rb_q   <= soh_rb_d;
            soh_i_q    <= soh_i_d;
            soh_s_q    <= soh_s_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = (rsp_ready || timeout) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        soh_rb_d   = accept ? (gnt ? req1_rb : req0_rb) : soh_rb_q;
        soh_i_d    = accept ? (gnt ? req1_imm : req0_imm) : soh_i_q;
        soh_s_d    = accept ? (gnt ? req1_sel : req0_sel) : soh_s_q;
        rsp_id_d   = accept ? gnt : rsp_id_q;
        last_d     = accept ? gnt : last_q;
        rsp_data_d = (state_q == EXEC) ? soh_n : rsp_data_q;
        // Zero outside RESP, so it is already clear on entry and after a drop.
        cnt_d      = ((state_q == RESP) && !rsp_ready && !timeout) ? cnt_q + 8'd1 : 8'd0;
    end
    always_comb begin
        busy        = (state_q != IDLE);
        rsp_valid   = (state_q == RESP);
        timeout_err = timeout;
        soh_rb      = soh_rb_q;
        soh_i       = soh_i_q;
        soh_s       = soh_s_q;
        rsp_id      = rsp_id_q;
        rsp_data    = rsp_data_q;
    end
endmodule

// File: tb/tb_soh_arbiter.sv
// tb_soh_arbiter: directed self-checking bench for soh_arbiter
module tb_soh_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req0_rb = '0, req1_rb = '0;
    logic [20:0] req0_imm = '0, req1_imm = '0;
    logic [2:0]  req0_sel = '0, req1_sel = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy, timeout_err;
    logic [31:0] soh_rb, soh_n, rsp_data;
    logic [20:0] soh_i;
    logic [2:0]  soh_s;
    logic        t_req0_valid = 1'b0, t_rsp_ready = 1'b0;
    logic [31:0] t_rb = 32'h0000_0055;
    logic        t_req0_ready, t_req1_ready, t_rsp_valid, t_rsp_id, t_busy, t_timeout_err;
    logic [31:0] t_soh_rb, t_soh_n, t_rsp_data;
    logic [20:0] t_soh_i;
    logic [2:0]  t_soh_s;
    int n_cmp = 0, n_err = 0, n_done = 0, n_to = 0, n_t_done = 0, n_t_to = 0;
    int g[$], gc[$], nr, exp_g[4];
    logic [31:0] exp;
    always #5 clk = ~clk;
    function automatic logic [31:0] soh_model(input logic [31:0] rb, input logic [20:0] imm, input logic [2:0] sel);
        return rb + {11'b0, imm} + {29'b0, sel};
    endfunction
    assign soh_n   = soh_model(soh_rb, soh_i, soh_s);
    assign t_soh_n = soh_model(t_soh_rb, t_soh_i, t_soh_s);
    soh_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rb(req0_rb), .req0_imm(req0_imm), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rb(req1_rb), .req1_imm(req1_imm), .req1_sel(req1_sel),
        .soh_rb(soh_rb), .soh_i(soh_i), .soh_s(soh_s), .soh_n(soh_n),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .timeout_err(timeout_err)
    );
    soh_arbiter #(.HOLD_TIMEOUT(3)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_rb(t_rb), .req0_imm(21'd0), .req0_sel(3'd0),
        .req1_valid(1'b0), .req1_ready(t_req1_ready), .req1_rb(32'd0), .req1_imm(21'd0), .req1_sel(3'd0),
        .soh_rb(t_soh_rb), .soh_i(t_soh_i), .soh_s(t_soh_s), .soh_n(t_soh_n),
        .rsp_valid(t_rsp_valid), .rsp_id(t_rsp_id), .rsp_data(t_rsp_data), .rsp_ready(t_rsp_ready),
        .busy(t_busy), .timeout_err(t_timeout_err)
    );
    always @(posedge clk) begin
        if (rsp_valid && rsp_ready) n_done++;
        if (timeout_err) n_to++;
        if (t_rsp_valid && t_rsp_ready) n_t_done++;
        if (t_timeout_err) n_t_to++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_soh_rb", soh_rb, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_t_busy", t_busy, 0);
        rst_n = 1'b1;
        // single request from requester 0
        tick();
        req0_valid = 1'b1; req0_rb = 32'h0000_00F0; req0_imm = '0; req0_sel = '0; rsp_ready = 1'b1;
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        tick();
        #1;
        check("t1_exec_ready0", req0_ready, 0);
        check("t1_exec_busy", busy, 1);
        check("t1_exec_rsp_valid", rsp_valid, 0);
        check("t1_soh_rb", soh_rb, 32'h0000_00F0);
        req0_valid = 1'b0;
        tick();
        #1;
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_id", rsp_id, 0);
        check("t1_rsp_data", rsp_data, 32'h0000_00F0);
        tick();
        #1;
        check("t1_idle_rsp_valid", rsp_valid, 0);
        check("t1_idle_busy", busy, 0);
        // valid withdrawn before the edge: no grant, no state change
        req1_valid = 1'b1;
        #1;
        check("wd_ready_up", req1_ready, 1);
        req1_valid = 1'b0;
        #1;
        check("wd_ready_down", req1_ready, 0);
        tick();
        #1;
        check("wd_busy", busy, 0);
        // stalled response, selector 111 forwarded
        req1_valid = 1'b1; req1_rb = 32'h1234_5678; req1_imm = 21'h1F_FFFF; req1_sel = 3'b111; rsp_ready = 1'b0;
        exp = 32'h1234_5678 + 32'h001F_FFFF + 32'd7;
        #1;
        check("st_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        nr = n_done;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            #1;
            check("st_rsp_valid", rsp_valid, 1);
            check("st_rsp_data", rsp_data, exp);
            check("st_rsp_id", rsp_id, 1);
            check("st_soh_s", soh_s, 3'b111);
            check("st_ready0_blocked", req0_ready, 0);
            check("st_timeout", timeout_err, 0);
            tick();
        end
        req0_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        check("st_final_data", rsp_data, exp);
        tick();
        #1;
        check("st_done_rsp_valid", rsp_valid, 0);
        check("st_completions", n_done - nr, 1);
        check("st_timeout_count", n_to, 0);
        // reset during EXEC
        req0_valid = 1'b1; req0_rb = 32'h0000_AAAA; req0_imm = 21'd5; req0_sel = 3'd2;
        #1;
        check("rx_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("rx_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rx_busy", busy, 0);
        check("rx_rsp_valid", rsp_valid, 0);
        check("rx_rsp_id", rsp_id, 0);
        check("rx_rsp_data", rsp_data, 0);
        check("rx_soh_rb", soh_rb, 0);
        check("rx_soh_i", soh_i, 0);
        check("rx_soh_s", soh_s, 0);
        check("rx_timeout", timeout_err, 0);
        tick();
        rst_n = 1'b1;
        // both requesters valid continuously
`ifdef SOH_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        req0_valid = 1'b1; req0_rb = 32'h0000_0100; req0_imm = 21'd1; req0_sel = 3'd0;
        req1_valid = 1'b1; req1_rb = 32'h0000_0200; req1_imm = 21'd2; req1_sel = 3'd1;
        rsp_ready = 1'b1; nr = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            check("rr_exclusive", req0_ready & req1_ready, 0);
            if (req0_ready || req1_ready) begin
                g.push_back(int'(req1_ready));
                gc.push_back(c);
            end
            if (rsp_valid && nr < g.size()) begin
                check("rr_rsp_id", rsp_id, g[nr]);
                check("rr_rsp_data", rsp_data, g[nr] != 0 ? soh_model(32'h200, 21'd2, 3'd1) : soh_model(32'h100, 21'd1, 3'd0));
                nr++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_grants", g.size(), 4);
        check("rr_responses", nr, 4);
        if (g.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("rr_grant", g[i], exp_g[i]);
                if (i > 0) check("rr_spacing", gc[i] - gc[i-1], 3);
            end
        end
        // timeout with HOLD_TIMEOUT=3
        t_rsp_ready = 1'b0; t_req0_valid = 1'b1;
        #1;
        check("to_ready", t_req0_ready, 1);
        tick();
        t_req0_valid = 1'b0;
        #1;
        check("to_exec_busy", t_busy, 1);
        check("to_exec_rsp_valid", t_rsp_valid, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("to_rsp_valid", t_rsp_valid, 1);
            check("to_pulse", t_timeout_err, i == 2);
            tick();
        end
        #1;
        check("to_idle_rsp_valid", t_rsp_valid, 0);
        check("to_idle_busy", t_busy, 0);
        check("to_idle_err", t_timeout_err, 0);
        check("to_pulses", n_t_to, 1);
        check("to_no_completion", n_t_done, 0);
        t_req0_valid = 1'b1;
        #1;
        check("to_next_ready", t_req0_ready, 1);
        tick();
        t_req0_valid = 1'b0;
        #1;
        check("to_next_busy", t_busy, 1);
        tick();
        tick();
        tick();
        t_rsp_ready = 1'b1;
        #1;
        check("tb_edge_err", t_timeout_err, 0);
        check("tb_edge_valid", t_rsp_valid, 1);
        check("tb_edge_data", t_rsp_data, soh_model(32'h55, 21'd0, 3'd0));
        tick();
        #1;
        check("tb_edge_idle", t_rsp_valid, 0);
        check("tb_edge_pulses", n_t_to, 1);
        check("tb_edge_completion", n_t_done, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
